syn_current: RTL and testbench

//  Synapse stage between presynaptic LIF spike output and postsynaptic LIF current input.

---
 rtl/syn_current.sv | 151 +++++++++++++++
 tb/tb_syn_current.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/syn_current.sv
// syn_current: synapse current stage between a presynaptic and a postsynaptic LIF neuron.
// Latency: an accepted pre_spike updates current_out at the clock edge ending the spike cycle.
// Backpressure: none; spikes arrive as single-cycle pulses and are never stalled.
// Optional feature: define SYN_REFRACT_EN to build a refractory window after each accepted spike.
module syn_current #(
  parameter logic [7:0] W_INIT      = 8'd32,
  parameter int         DECAY_SHIFT = 2,
  parameter int         TICK_DIV    = 4
`ifdef SYN_REFRACT_EN
  ,
  parameter int         REFRACT_CYC = 3
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pre_spike,
  input  logic [7:0] weight_in,
  input  logic       w_update,
  output logic [7:0] current_out,
  output logic [7:0] weight_q,
  output logic       active,
  output logic       sat
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  // Tick counter wide enough for 0..TICK_DIV-1; a divider of 1 still gets a 1-bit counter.
  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [7:0]    cur_q, cur_d;
  logic [7:0]    weight_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          active_q, active_d;
  logic          sat_q, sat_d;

  logic          spike_acc;
  logic [8:0]    sum9;
  logic [7:0]    add_val;
  logic [7:0]    dec_raw;
  logic [7:0]    dec_step;
  logic          tick_wrap;
  logic          spike_live;

`ifdef SYN_REFRACT_EN
  // The spike cycle itself is the first cycle of the window, so the counter
  // loads REFRACT_CYC-1 and spikes are accepted again REFRACT_CYC cycles later.
  localparam int            RW        = (REFRACT_CYC > 1) ? $clog2(REFRACT_CYC) : 1;
  localparam logic [RW-1:0] REFR_LOAD = (REFRACT_CYC > 0) ? RW'(REFRACT_CYC - 1) : '0;

  logic [RW-1:0] refr_q, refr_d;

  assign spike_acc = pre_spike && (refr_q == '0);

  // Refractory counter: load on an accepted spike, otherwise count down to zero.
  always_comb begin
    refr_d = refr_q;
    if (spike_acc) begin
      refr_d = REFR_LOAD;
    end else if (refr_q != '0) begin
      refr_d = refr_q - 1'b1;
    end
  end

  // Refractory counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refr_q <= '0;
    end else begin
      refr_q <= refr_d;
    end
  end
`else
  assign spike_acc = pre_spike;
`endif

  // Saturating add of the applied weight, and the decay step with a floor of 1.
  assign sum9       = {1'b0, cur_q} + {1'b0, weight_q};
  assign add_val    = sum9[8] ? 8'hFF : sum9[7:0];
  assign dec_raw    = cur_q >> DECAY_SHIFT;
  assign dec_step   = (dec_raw == 8'd0) ? 8'd1 : dec_raw;
  assign tick_wrap  = (tick_q == TICK_LAST);
  // A spike only keeps or starts activity when the weight it adds is non-zero.
  assign spike_live = spike_acc && (weight_q != 8'd0);

  // Next-state logic: spike add has priority over decay; weight update always uses
  // the incoming value while the same-cycle add sees the old weight_q.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    tick_d   = tick_q;
    sat_d    = sat_q;
    weight_d = w_update ? weight_in : weight_q;

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (spike_live) begin
          cur_d   = add_val;
          sat_d   = sat_q | sum9[8];
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        tick_d = tick_wrap ? '0 : tick_q + 1'b1;
        if (spike_acc) begin
          cur_d = add_val;
          sat_d = sat_q | sum9[8];
        end else if (tick_wrap && (cur_q != 8'd0)) begin
          cur_d = cur_q - dec_step;
        end
        // Current already drained: fall back to idle unless a new spike refills it.
        if ((cur_q == 8'd0) && !spike_live) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase

    active_d = (state_d == S_ACTIVE);
  end

  // State registers; asynchronous reset returns everything to its idle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cur_q    <= 8'd0;
      weight_q <= W_INIT;
      tick_q   <= '0;
      active_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      weight_q <= weight_d;
      tick_q   <= tick_d;
      active_q <= active_d;
      sat_q    <= sat_d;
    end
  end

  assign current_out = cur_q;
  assign active      = active_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_syn_current.sv
// Testbench for syn_current: per-cycle vector table with expected outputs,
// plus a hand-written asynchronous reset sequence.
module tb_syn_current;

  logic       clk;
  logic       rst;
  logic       pre_spike;
  logic [7:0] weight_in;
  logic       w_update;
  logic [7:0] current_out;
  logic [7:0] weight_q;
  logic       active;
  logic       sat;

  int n_chk;
  int n_fail;

  typedef struct {
    bit       rst;
    bit       pre;
    bit       wu;
    bit [7:0] win;
    bit [7:0] cur;
    bit [7:0] w;
    bit       act;
    bit       sat;
  } vec_t;

  vec_t vq[$];

  int dec_seq [13] = '{24, 18, 14, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0};

  syn_current dut (
    .clk         (clk),
    .rst         (rst),
    .pre_spike   (pre_spike),
    .weight_in   (weight_in),
    .w_update    (w_update),
    .current_out (current_out),
    .weight_q    (weight_q),
    .active      (active),
    .sat         (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void v(input bit r, input bit p, input bit u, input bit [7:0] wi,
                            input bit [7:0] c, input bit [7:0] w, input bit a, input bit s);
    vec_t e;
    e.rst = r; e.pre = p; e.wu = u; e.win = wi;
    e.cur = c; e.w = w; e.act = a; e.sat = s;
    vq.push_back(e);
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got %0d, expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic chk_all(input int idx, input bit [7:0] c, input bit [7:0] w, input bit a, input bit s);
    chk("current_out", idx, current_out, c);
    chk("weight_q",    idx, weight_q, w);
    chk("active",      idx, {7'd0, active}, {7'd0, a});
    chk("sat",         idx, {7'd0, sat}, {7'd0, s});
  endtask

  initial begin
    int prev;
    n_chk  = 0;
    n_fail = 0;

    // Single spike, then exponential decay every 4 cycles down to 0.
    v(0, 1, 0, 0, 32, 32, 1, 0);
    prev = 32;
    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < 3; k++) v(0, 0, 0, 0, prev[7:0], 32, 1, 0);
      v(0, 0, 0, 0, dec_seq[i][7:0], 32, 1, 0);
      prev = dec_seq[i];
    end
    v(0, 0, 0, 0, 0, 32, 0, 0);
    v(0, 0, 0, 0, 0, 32, 0, 0);

    // Same-cycle weight update and spike: add uses the old weight.
    v(0, 1, 1, 100, 32, 100, 1, 0);
    v(0, 1, 0, 0, 132, 100, 1, 0);
    v(0, 0, 0, 0, 132, 100, 1, 0);
    v(0, 0, 0, 0, 132, 100, 1, 0);
    v(0, 0, 0, 0, 99, 100, 1, 0);
    v(1, 0, 0, 0, 0, 32, 0, 0);

    // Saturation; sat stays sticky through decay and further adds.
    v(0, 0, 1, 200, 0, 200, 0, 0);
    v(0, 1, 0, 0, 200, 200, 1, 0);
    v(0, 1, 0, 0, 255, 200, 1, 1);
    v(0, 0, 0, 0, 255, 200, 1, 1);
    v(0, 0, 0, 0, 255, 200, 1, 1);
    v(0, 0, 0, 0, 192, 200, 1, 1);
    v(0, 1, 0, 0, 255, 200, 1, 1);
    v(1, 0, 0, 0, 0, 32, 0, 0);

    // Spike on the tick-wrap cycle: add wins, decay for that tick skipped.
    v(0, 1, 0, 0, 32, 32, 1, 0);
    for (int k = 0; k < 3; k++) v(0, 0, 0, 0, 32, 32, 1, 0);
    v(0, 0, 0, 0, 24, 32, 1, 0);
    for (int k = 0; k < 3; k++) v(0, 0, 0, 0, 24, 32, 1, 0);
    v(0, 1, 0, 0, 56, 32, 1, 0);
    for (int k = 0; k < 3; k++) v(0, 0, 0, 0, 56, 32, 1, 0);
    v(0, 0, 0, 0, 42, 32, 1, 0);
    v(1, 0, 0, 0, 0, 32, 0, 0);

    // Back-to-back spikes on four consecutive cycles.
`ifdef SYN_REFRACT_EN
    v(0, 1, 0, 0, 32, 32, 1, 0);
    v(0, 1, 0, 0, 32, 32, 1, 0);
    v(0, 1, 0, 0, 32, 32, 1, 0);
    v(0, 1, 0, 0, 64, 32, 1, 0);
`else
    v(0, 1, 0, 0, 32, 32, 1, 0);
    v(0, 1, 0, 0, 64, 32, 1, 0);
    v(0, 1, 0, 0, 96, 32, 1, 0);
    v(0, 1, 0, 0, 128, 32, 1, 0);
`endif
    v(1, 0, 0, 0, 0, 32, 0, 0);

    // Zero weight: spikes leave the block idle; minimum decay step of 1.
    v(0, 0, 1, 0, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0, 0);
    v(0, 1, 1, 5, 0, 5, 0, 0);
    v(0, 0, 0, 0, 0, 5, 0, 0);
    v(0, 1, 0, 0, 5, 5, 1, 0);
    for (int k = 0; k < 3; k++) v(0, 0, 0, 0, 5, 5, 1, 0);
    v(0, 0, 0, 0, 4, 5, 1, 0);

    // Power-on reset.
    rst       = 1'b1;
    pre_spike = 1'b0;
    w_update  = 1'b0;
    weight_in = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all(-1, 0, 32, 0, 0);
    rst = 1'b0;

    // Apply vectors: drive just after an edge, check just after the next edge.
    for (int i = 0; i < vq.size(); i++) begin
      rst       = vq[i].rst;
      pre_spike = vq[i].pre;
      w_update  = vq[i].wu;
      weight_in = vq[i].win;
      @(posedge clk);
      #1;
      chk_all(i, vq[i].cur, vq[i].w, vq[i].act, vq[i].sat);
    end

    // Asynchronous reset mid-decay: outputs must clear before the next edge.
    rst       = 1'b0;
    pre_spike = 1'b0;
    w_update  = 1'b0;
    weight_in = 8'd0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_all(1000, 0, 32, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all(1001, 0, 32, 0, 0);

    // Recovery after reset: a fresh spike adds the reset weight.
    pre_spike = 1'b1;
    @(posedge clk);
    #1;
    pre_spike = 1'b0;
    chk_all(1002, 32, 32, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
